// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: freeze/flush sequencer for the 5-stage pipeline.
// Holds the IF register and inserts ID/EX bubbles on data hazards, flushes IF/ID
// on a taken branch, and freezes the whole pipe while a data-memory access is busy.
// Optional feature macro: HAZARD_FORWARDING_EN. When it is defined, only load-use
// hazards stall. When it is undefined, any EX or MEM writeback that matches an ID
// source stalls.
//
// Handshake: the memory access is busy while mem_req=1 and mem_ready=0. The cycle
// with mem_ready=1, or the cycle in which mem_req drops, is the completion cycle.
// That cycle is not frozen.
// Freeze always wins over flush at every pipeline register.
module pipeline_hazard_ctrl #(
    parameter int REG_W       = 4,
    parameter int TMO_W       = 8,
    parameter int MEM_TIMEOUT = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic             id_valid,
    input  logic             ex_wb_en,
    input  logic [REG_W-1:0] ex_dest,
    input  logic             ex_mem_read,
    input  logic             mem_wb_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_freeze,
    output logic             if_flush,
    output logic             id_flush,
    output logic             pipe_freeze,
    output logic             mem_timeout,
    output logic [31:0]      stall_cnt,
    output logic             state_dbg
);

    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] MEM_WAIT = 1'b1;

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_cnt_nxt;
    logic             tmo_hit;

    logic ex_hit;
    logic mem_hit;
    logic data_hz;
    logic mem_busy;

    logic pc_en_c;
    logic if_freeze_c;
    logic if_flush_c;
    logic id_flush_c;
    logic pipe_freeze_c;

    // Register 0 is compared like any other index.
    assign ex_hit  = (id_valid & (id_src1 == ex_dest))  | (id_two_src & (id_src2 == ex_dest));
    assign mem_hit = (id_valid & (id_src1 == mem_dest)) | (id_two_src & (id_src2 == mem_dest));

`ifdef HAZARD_FORWARDING_EN
    // Forwarding covers ALU results. Only a load in EX cannot be forwarded in time.
    assign data_hz = ex_wb_en & ex_mem_read & ex_hit;
    logic unused_mem_fields;
    assign unused_mem_fields = &{1'b0, mem_wb_en, mem_hit};
`else
    // There is no forwarding, so any pending writeback to a source register stalls.
    assign data_hz = (ex_wb_en & ex_hit) | (mem_wb_en & mem_hit);
    logic unused_load_flag;
    assign unused_load_flag = &{1'b0, ex_mem_read};
`endif

    assign mem_busy = mem_req & ~mem_ready;

    // Next-state and control decode. A busy access freezes everything in either state.
    // Otherwise the RUN priority applies: branch first, then the data hazard.
    always_comb begin
        pc_en_c       = 1'b1;
        if_freeze_c   = 1'b0;
        if_flush_c    = 1'b0;
        id_flush_c    = 1'b0;
        pipe_freeze_c = 1'b0;
        state_nxt     = RUN;
        tmo_cnt_nxt   = tmo_cnt;
        tmo_hit       = 1'b0;
        if (mem_busy) begin
            pc_en_c       = 1'b0;
            if_freeze_c   = 1'b1;
            pipe_freeze_c = 1'b1;
            state_nxt     = MEM_WAIT;
            if (state == RUN) begin
                tmo_cnt_nxt = TMO_W'(1);
            end else if (tmo_cnt != {TMO_W{1'b1}}) begin
                tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
            end
            tmo_hit = (tmo_cnt_nxt == TMO_W'(MEM_TIMEOUT));
        end else if (branch_taken) begin
            // The ID instruction is squashed, so a coincident hazard does not matter.
            if_flush_c = 1'b1;
            id_flush_c = 1'b1;
        end else if (data_hz) begin
            pc_en_c     = 1'b0;
            if_freeze_c = 1'b1;
            id_flush_c  = 1'b1;
        end
    end

    // Reset releases every hold at once, without waiting for a clock edge.
    assign pc_en       = rst | pc_en_c;
    assign if_freeze   = ~rst & if_freeze_c;
    assign if_flush    = ~rst & if_flush_c;
    assign id_flush    = ~rst & id_flush_c;
    assign pipe_freeze = ~rst & pipe_freeze_c;
    assign state_dbg   = state[0];

    // State, wait counter, sticky timeout flag and stall-cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            tmo_cnt     <= '0;
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= tmo_cnt_nxt;
            if (tmo_hit) begin
                mem_timeout <= 1'b1;
            end
            if (!pc_en_c) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and random stimulus for pipeline_hazard_ctrl.
// A behavioural model predicts the outputs of each cycle. The prediction is queued,
// then popped and compared once the combinational outputs have settled.
module tb_pipeline_hazard_ctrl;

    localparam int REG_W  = 4;
    localparam int TMO_W  = 8;
    localparam int TMO    = 4;
    localparam int CNT_MAX = (1 << TMO_W) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [REG_W-1:0] id_src1, id_src2, ex_dest, mem_dest;
    logic id_two_src, id_valid, ex_wb_en, ex_mem_read, mem_wb_en;
    logic branch_taken, mem_req, mem_ready;
    logic pc_en, if_freeze, if_flush, id_flush, pipe_freeze, mem_timeout, state_dbg;
    logic [31:0] stall_cnt;

    pipeline_hazard_ctrl #(
        .REG_W      (REG_W),
        .TMO_W      (TMO_W),
        .MEM_TIMEOUT(TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_src1     (id_src1),
        .id_src2     (id_src2),
        .id_two_src  (id_two_src),
        .id_valid    (id_valid),
        .ex_wb_en    (ex_wb_en),
        .ex_dest     (ex_dest),
        .ex_mem_read (ex_mem_read),
        .mem_wb_en   (mem_wb_en),
        .mem_dest    (mem_dest),
        .branch_taken(branch_taken),
        .mem_req     (mem_req),
        .mem_ready   (mem_ready),
        .pc_en       (pc_en),
        .if_freeze   (if_freeze),
        .if_flush    (if_flush),
        .id_flush    (id_flush),
        .pipe_freeze (pipe_freeze),
        .mem_timeout (mem_timeout),
        .stall_cnt   (stall_cnt),
        .state_dbg   (state_dbg)
    );

    // ---------------- scoreboard ----------------
    // Vector layout: {pc_en, if_freeze, if_flush, id_flush, pipe_freeze, mem_timeout, stall_cnt, state}
    localparam int VW = 39;
    logic [VW-1:0] exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    // Model state: the value each DUT register holds during the current cycle.
    logic        m_wait  = 1'b0;
    int          m_cnt   = 0;
    logic        m_tmo   = 1'b0;
    logic [31:0] m_stall = '0;

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        id_src1 = '0; id_src2 = '0; ex_dest = '0; mem_dest = '0;
        id_two_src = 1'b0; id_valid = 1'b0; ex_wb_en = 1'b0; ex_mem_read = 1'b0;
        mem_wb_en = 1'b0; branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic set_load_use();
        ex_mem_read = 1'b1; ex_wb_en = 1'b1; ex_dest = 4'd3; id_src1 = 4'd3; id_valid = 1'b1;
    endtask

    // Inputs are already driven, just after a falling edge. This task predicts,
    // checks after the outputs settle, and advances the model across the next
    // rising edge.
    task automatic step(input string tag);
        logic hit_ex, hit_mem, hz, busy;
        logic e_pc, e_iff, e_ifl, e_idf, e_pf;
        logic [VW-1:0] exp_v, obs_v;

        hit_ex  = (id_valid && id_src1 == ex_dest)  || (id_two_src && id_src2 == ex_dest);
        hit_mem = (id_valid && id_src1 == mem_dest) || (id_two_src && id_src2 == mem_dest);
`ifdef HAZARD_FORWARDING_EN
        hz = ex_wb_en && ex_mem_read && hit_ex;
`else
        hz = (ex_wb_en && hit_ex) || (mem_wb_en && hit_mem);
`endif
        busy = mem_req && !mem_ready;

        if (rst) begin
            m_wait = 1'b0; m_cnt = 0; m_tmo = 1'b0; m_stall = '0;
        end

        e_pc = 1'b1; e_iff = 1'b0; e_ifl = 1'b0; e_idf = 1'b0; e_pf = 1'b0;
        if (!rst) begin
            if (m_wait && mem_req && !mem_ready) begin
                e_pc = 1'b0; e_iff = 1'b1; e_pf = 1'b1;
            end else if (!m_wait && busy) begin
                e_pc = 1'b0; e_iff = 1'b1; e_pf = 1'b1;
            end else if (branch_taken) begin
                e_ifl = 1'b1; e_idf = 1'b1;
            end else if (hz) begin
                e_pc = 1'b0; e_iff = 1'b1; e_idf = 1'b1;
            end
        end

        exp_v = {e_pc, e_iff, e_ifl, e_idf, e_pf, m_tmo, m_stall, m_wait};
        exp_q.push_back(exp_v);

        #1;
        obs_v = {pc_en, if_freeze, if_flush, id_flush, pipe_freeze, mem_timeout, stall_cnt, state_dbg};
        exp_v = exp_q.pop_front();
        vectors++;
        assert (obs_v === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs_v, exp_v);
        end

        if (!rst) begin
            if (!m_wait) begin
                if (busy) begin
                    m_wait = 1'b1;
                    m_cnt  = 1;
                end
            end else if (mem_ready || !mem_req) begin
                m_wait = 1'b0;
            end else begin
                if (m_cnt < CNT_MAX) m_cnt++;
                if (m_cnt == TMO) m_tmo = 1'b1;
            end
            if (!e_pc) m_stall = m_stall + 32'd1;
        end
        @(negedge clk);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        clear_inputs();
        #2 rst = 1'b1;                   // reset asserted between clock edges
        @(negedge clk);
        step("reset_hold");
        step("reset_hold2");
        rst = 1'b0;
        step("idle0");
        step("idle1");

        // Load-use hazard: stalls for one cycle and counts one stall.
        set_load_use();
        step("load_use");
        clear_inputs();
        step("after_load_use");

        // Branch squashes the hazarding instruction.
        set_load_use(); branch_taken = 1'b1;
        step("branch_hz");
        clear_inputs();
        step("after_branch");

        // ALU result in EX: stalls only without forwarding.
        ex_wb_en = 1'b1; ex_dest = 4'd5; id_two_src = 1'b1; id_src2 = 4'd5;
        step("ex_alu_dep");
        clear_inputs();

        // MEM-stage writeback to src2: stalls only without forwarding.
        mem_wb_en = 1'b1; mem_dest = 4'd7; id_two_src = 1'b1; id_src2 = 4'd7;
        step("mem_dep");
        clear_inputs();
        step("after_mem_dep");

        // src1 matches, but id_valid is low, so there is no hazard.
        ex_wb_en = 1'b1; ex_mem_read = 1'b1; ex_dest = 4'd9; id_src1 = 4'd9;
        step("src1_invalid");
        // Register 0 is an ordinary index.
        ex_dest = 4'd0; id_src1 = 4'd0; id_valid = 1'b1;
        step("reg0_hz");
        clear_inputs();

        // Memory wait: busy for 5 cycles, then ready. The timeout reaches 4 during the wait.
        mem_req = 1'b1;
        for (int i = 0; i < 5; i++) step($sformatf("mem_wait%0d", i));
        mem_ready = 1'b1;
        step("mem_release");
        clear_inputs();
        step("after_release_sticky");
        step("sticky2");

        // A reset pulse between clock edges clears the sticky flag and the counters.
        rst = 1'b1;
        step("reset_mid");
        rst = 1'b0;
        step("post_reset");

        // Branch held throughout the wait: the flush appears only in the release cycle.
        mem_req = 1'b1; branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) step($sformatf("wait_branch%0d", i));
        mem_ready = 1'b1;
        step("branch_release");
        clear_inputs();

        // Dropping mem_req while not ready also releases the wait.
        mem_req = 1'b1;
        step("drop_wait0");
        step("drop_wait1");
        mem_req = 1'b0;
        set_load_use();
        step("drop_release_hz");
        clear_inputs();
        step("drop_idle");

        // Reset in the middle of a wait releases the outputs at once.
        mem_req = 1'b1;
        step("rst_wait0");
        step("rst_wait1");
        rst = 1'b1;
        step("rst_in_wait");
        rst = 1'b0;
        clear_inputs();
        step("rst_wait_after");

        // Random traffic over a small register range.
        for (int i = 0; i < 300; i++) begin
            id_src1      = REG_W'($urandom_range(0, 3));
            id_src2      = REG_W'($urandom_range(0, 3));
            ex_dest      = REG_W'($urandom_range(0, 3));
            mem_dest     = REG_W'($urandom_range(0, 3));
            id_two_src   = 1'($urandom_range(0, 1));
            id_valid     = 1'($urandom_range(0, 1));
            ex_wb_en     = 1'($urandom_range(0, 1));
            ex_mem_read  = 1'($urandom_range(0, 1));
            mem_wb_en    = 1'($urandom_range(0, 1));
            branch_taken = ($urandom_range(0, 3) == 0);
            mem_req      = ($urandom_range(0, 3) == 0) ? 1'b1 : (m_wait && $urandom_range(0, 3) != 0);
            mem_ready    = ($urandom_range(0, 2) == 0);
            rst          = ($urandom_range(0, 99) == 0);
            step($sformatf("rand%0d", i));
        end
        rst = 1'b0;
        clear_inputs();
        step("final_idle");

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central freeze/flush sequencer for the 5-stage pipeline.
- Drives the freeze/flush pins of the IF stage register, the bubble insertion into ID/EX, and a whole-pipe freeze for multi-cycle data-memory accesses.
- Inputs: hazard detection from ID/EX/MEM source and destination fields, branch-taken from EX, and the SRAM ready handshake.
- Freeze always has priority over flush at every pipeline register.

Parameters:
- REG_W, 4, register-index width.
- TMO_W, 8, width of the memory-wait timeout counter.
- MEM_TIMEOUT, 200, max wait cycles before the timeout error is flagged.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_src1  in  REG_W  ID-stage source register 1.
- id_src2  in  REG_W  ID-stage source register 2.
- id_two_src  in  1  ID instruction reads src2.
- id_valid  in  1  ID holds a real instruction that reads src1.
- ex_wb_en  in  1  EX-stage instruction writes back.
- ex_dest  in  REG_W  EX-stage destination register.
- ex_mem_read  in  1  EX-stage instruction is a load.
- mem_wb_en  in  1  MEM-stage instruction writes back.
- mem_dest  in  REG_W  MEM-stage destination register.
- branch_taken  in  1  EX resolved a taken branch.
- mem_req  in  1  MEM stage issues a load or store.
- mem_ready  in  1  SRAM access complete.
- pc_en  out  1  PC register load enable.
- if_freeze  out  1  to IF stage register freeze.
- if_flush  out  1  to IF stage register flush.
- id_flush  out  1  zero the ID/EX register (bubble).
- pipe_freeze  out  1  freeze the ID/EX, EX/MEM and MEM/WB registers.
- mem_timeout  out  1  sticky error flag.
- stall_cnt  out  32  count of cycles with pc_en=0.

Behaviour:
- States: RUN, MEM_WAIT. Only the state, timeout counter, mem_timeout and stall_cnt are registered. All freeze/flush outputs are combinational from state and inputs, so they take effect in the same cycle.
- Reset (asynchronous): state=RUN, counter=0, mem_timeout=0, stall_cnt=0. While rst=1: pc_en=1 and all freeze/flush outputs are 0.
- src_hit(d) = (id_valid & id_src1==d) | (id_two_src & id_src2==d).
- data_hz = ex_wb_en & ex_mem_read & src_hit(ex_dest). The definition widens when the optional feature is off (see below).
- mem_busy = mem_req & ~mem_ready.
- RUN, priority high to low:
  - mem_busy: pipe_freeze=1, if_freeze=1, pc_en=0, if_flush=0, id_flush=0. Next state MEM_WAIT, counter cleared to 1.
  - branch_taken: pc_en=1, if_flush=1, id_flush=1, no freeze. A branch overrides a simultaneous data_hz, because the hazarding ID instruction is squashed.
  - data_hz: pc_en=0, if_freeze=1, id_flush=1. Lasts one cycle per hazard evaluation, with no state change.
  - Otherwise: pc_en=1 and all other control outputs 0.
- MEM_WAIT:
  - pipe_freeze=1, if_freeze=1, pc_en=0. All flushes are suppressed; a pending branch_taken is held by the frozen EX/MEM and acted on after release.
  - mem_ready=1: outputs for this cycle are the RUN outputs computed as if mem_busy=0; next state RUN. The releasing cycle is therefore not frozen.
  - mem_ready=0: counter increments, saturating at all-ones. When the counter reaches MEM_TIMEOUT, mem_timeout is set. It stays set (sticky) until reset. The FSM keeps waiting; there is no forced exit.
  - mem_req dropping while mem_ready=0 counts as a release: go to RUN.
- stall_cnt increments every cycle where pc_en=0 and rst=0, and wraps at 2^32.
- Reset asserted mid-MEM_WAIT returns to RUN immediately. Outputs are released asynchronously.

Optional Feature:
- Macro: HAZARD_FORWARDING_EN.
- Defined: a forwarding unit exists, so only load-use hazards stall, with data_hz as defined above.
- Undefined: no forwarding. data_hz = (ex_wb_en & src_hit(ex_dest)) | (mem_wb_en & src_hit(mem_dest)). Each matching cycle stalls IF and bubbles ID.
- Register index 0 receives no special treatment in either configuration.

Test Plan:
- Reset: rst pulse mid-cycle, then clk running with all inputs 0 → pc_en=1, every other output 0, stall_cnt=0.
- Load-use, forwarding on: ex_mem_read=1, ex_wb_en=1, ex_dest=3, id_src1=3, id_valid=1 for one cycle → that cycle pc_en=0, if_freeze=1, id_flush=1; the next cycle, with inputs cleared, pc_en=1; stall_cnt=1.
- Branch plus hazard: branch_taken=1 with the same load-use inputs → if_flush=1, id_flush=1, pc_en=1, if_freeze=0.
- Memory wait:
  - mem_req=1, mem_ready=0 for 5 cycles, then mem_ready=1 → pipe_freeze=1 for exactly 5 cycles and 0 in the ready cycle; state returns to RUN; stall_cnt=5.
  - branch_taken=1 throughout the wait → no flush until the ready cycle, where if_flush=1.
- Timeout: MEM_TIMEOUT=4, mem_req=1, mem_ready stuck at 0 → mem_timeout rises on the wait cycle where the counter reaches 4 and stays 1 after mem_ready=1, until rst.
- Macro off: mem_wb_en=1, mem_dest=7, id_two_src=1, id_src2=7 → one-cycle stall. The same stimulus with the macro defined → no stall.
